// File: rtl/zjh_tdm_demux4.sv
// Receive side of a 4-slot TDM link: tracks slot position against FrameSync,
// locks after LOCK_FRAMES good syncs and publishes whole frames in parallel.
module zjh_tdm_demux4 #(
  parameter int DATA_W      = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [DATA_W-1:0]     DateIn,
  input  logic                  FrameSync,
  output logic [4*DATA_W-1:0]   DateOut,
  output logic [1:0]            Sel,
  output logic                  Valid,
  output logic                  Locked,
  output logic                  SyncErr
);

  localparam int CW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  // A sync seen in HUNT (or an early realign) counts as the first good frame.
  localparam state_t ENTRY = (LOCK_FRAMES == 1) ? LOCKED : SYNC;

  state_t                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0][DATA_W-1:0]  sh_q, sh_d;
  logic                    pub, viol;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pub     = 1'b0;
    viol    = 1'b0;
    if (state_q == HUNT) begin
      if (FrameSync) begin
        sh_d[0] = DateIn;
        slot_d  = 2'd1;
        cnt_d   = CW'(1);
        state_d = ENTRY;
      end
    end else if (FrameSync != (slot_q == 2'd0)) begin
      viol = 1'b1;
      if (FrameSync) begin
        // early sync: treat this slot as slot 0 of a new frame
        sh_d[0] = DateIn;
        slot_d  = 2'd1;
        cnt_d   = CW'(1);
        state_d = ENTRY;
      end else begin
        state_d = HUNT;
        cnt_d   = '0;
        slot_d  = 2'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++)
        if (slot_q == 2'(i)) sh_d[i] = DateIn;
      slot_d = slot_q + 2'd1;
      if (slot_q == 2'd0 && state_q == SYNC) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LOCK_FRAMES - 1)) state_d = LOCKED;
      end
      // slot 3 is never stored; it goes straight into the published word
      pub = (state_q == LOCKED) && (slot_q == 2'd3);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
      sh_q    <= '0;
      DateOut <= '0;
      Valid   <= 1'b0;
      SyncErr <= 1'b0;
    end else if (Enable) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
      DateOut <= '0;
      Valid   <= 1'b0;
      SyncErr <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      if (pub) DateOut <= {DateIn, sh_q};
      Valid   <= pub;
      SyncErr <= viol;
    end
  end

  assign Sel    = slot_q;
  assign Locked = (state_q == LOCKED);

endmodule

// File: tb/tb_zjh_tdm_demux4.sv
// Scoreboard bench: two instances (1-bit/LOCK_FRAMES=2 and 2-bit/LOCK_FRAMES=1)
// checked cycle by cycle against a frame-level reference model.
module tb_zjh_tdm_demux4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, fs0;
  logic [0:0] din0;
  logic [3:0] dout0;
  logic [1:0] sel0;
  logic       val0, lk0, er0;

  logic       rst1, en1, fs1;
  logic [1:0] din1;
  logic [7:0] dout1;
  logic [1:0] sel1;
  logic       val1, lk1, er1;

  zjh_tdm_demux4 #(.DATA_W(1), .LOCK_FRAMES(2)) u_d0 (
    .Clk(clk), .Rst(rst0), .Enable(en0), .DateIn(din0), .FrameSync(fs0),
    .DateOut(dout0), .Sel(sel0), .Valid(val0), .Locked(lk0), .SyncErr(er0));

  zjh_tdm_demux4 #(.DATA_W(2), .LOCK_FRAMES(1)) u_d1 (
    .Clk(clk), .Rst(rst1), .Enable(en1), .DateIn(din1), .FrameSync(fs1),
    .DateOut(dout1), .Sel(sel1), .Valid(val1), .Locked(lk1), .SyncErr(er1));

  // pos: next expected slot, -1 while hunting; good: good syncs in this lock attempt
  typedef struct packed {
    logic signed [7:0] pos;
    logic signed [7:0] good;
    logic              lock;
    logic [3:0][7:0]   fr;
    logic [7:0]        dout;
  } mst_t;

  typedef struct packed {
    logic       valid;
    logic       locked;
    logic       err;
    logic [1:0] sel;
    logic [7:0] dout;
  } rec_t;

  mst_t m0, m1;
  rec_t st0[$], st1[$];
  logic [7:0] fq0[$], fq1[$];
  int n_vec = 0, n_err = 0;
  bit done = 1'b0;

  task automatic model(inout mst_t m, input logic rst, en, fs, input logic [7:0] din,
                       input int lf, input int w, output rec_t r, output bit pub,
                       output logic [7:0] pv);
    r = '0; pub = 1'b0; pv = '0;
    if (rst || en) begin
      m.pos = -1; m.good = 0; m.lock = 1'b0; m.dout = '0;
    end else if (m.pos < 0) begin
      if (fs) begin m.fr[0] = din; m.pos = 1; m.good = 1; m.lock = (lf == 1); end
    end else if (fs && m.pos == 0) begin
      m.fr[0] = din; m.pos = 1;
      if (!m.lock) begin m.good = m.good + 8'sd1; m.lock = (m.good >= lf); end
    end else if (!fs && m.pos != 0) begin
      m.fr[m.pos] = din;
      if (m.pos == 3 && m.lock) begin
        pub = 1'b1;
        pv = m.fr[0] | (m.fr[1] << w) | (m.fr[2] << (2*w)) | (din << (3*w));
        m.dout = pv;
      end
      m.pos = 8'((m.pos + 1) % 4);
    end else if (!fs) begin
      r.err = 1'b1; m.pos = -1; m.good = 0; m.lock = 1'b0;
    end else begin
      r.err = 1'b1; m.fr[0] = din; m.pos = 1; m.good = 1; m.lock = (lf == 1);
    end
    r.valid  = pub;
    r.locked = m.lock;
    r.sel    = (m.pos < 0) ? 2'd0 : m.pos[1:0];
    r.dout   = m.dout;
  endtask

  // Push expectations for the inputs now on the pins, then advance one cycle.
  task automatic apply();
    rec_t r;
    bit p;
    logic [7:0] pv;
    model(m0, rst0, en0, fs0, {7'b0, din0}, 2, 1, r, p, pv);
    st0.push_back(r);
    if (p) fq0.push_back(pv);
    model(m1, rst1, en1, fs1, {6'b0, din1}, 1, 2, r, p, pv);
    st1.push_back(r);
    if (p) fq1.push_back(pv);
    @(negedge clk);
  endtask

  task automatic send0(input logic [3:0] d, input logic [3:0] fm);
    for (int i = 0; i < 4; i++) begin
      din0 = d[i]; fs0 = fm[i];
      apply();
    end
    fs0 = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares every cycle's status and pops a frame whenever Valid is seen.
  initial begin
    rec_t r;
    logic [7:0] f;
    while (!done) begin
      @(posedge clk); #1;
      if (st0.size() > 0) begin
        r = st0.pop_front();
        chk("d0_valid",  {7'b0, val0}, {7'b0, r.valid});
        chk("d0_locked", {7'b0, lk0},  {7'b0, r.locked});
        chk("d0_syncerr",{7'b0, er0},  {7'b0, r.err});
        chk("d0_sel",    {6'b0, sel0}, {6'b0, r.sel});
        chk("d0_dateout",{4'b0, dout0}, r.dout);
        if (val0 === 1'b1) begin
          if (fq0.size() == 0) chk("d0_unexpected_frame", 8'd1, 8'd0);
          else begin f = fq0.pop_front(); chk("d0_frame", {4'b0, dout0}, f); end
        end
      end
      if (st1.size() > 0) begin
        r = st1.pop_front();
        chk("d1_valid",  {7'b0, val1}, {7'b0, r.valid});
        chk("d1_locked", {7'b0, lk1},  {7'b0, r.locked});
        chk("d1_syncerr",{7'b0, er1},  {7'b0, r.err});
        chk("d1_sel",    {6'b0, sel1}, {6'b0, r.sel});
        chk("d1_dateout", dout1, r.dout);
        if (val1 === 1'b1) begin
          if (fq1.size() == 0) chk("d1_unexpected_frame", 8'd1, 8'd0);
          else begin f = fq1.pop_front(); chk("d1_frame", dout1, f); end
        end
      end
    end
    chk("d0_frames_left", 8'(fq0.size()), 8'd0);
    chk("d1_frames_left", 8'(fq1.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [3:0][1:0] t6;
    int ph0, ph1;
    t6 = {2'b00, 2'b11, 2'b10, 2'b01};
    m0 = '0; m1 = '0; m0.pos = -1; m1.pos = -1;
    rst0 = 1'b1; en0 = 1'b0; fs0 = 1'b0; din0 = '0;
    rst1 = 1'b1; en1 = 1'b0; fs1 = 1'b0; din1 = '0;
    @(negedge clk);
    apply(); apply();
    rst0 = 1'b0; rst1 = 1'b0;

    // 2-bit / single-frame lock: first frame published as 8'b00111001
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) begin
        din1 = t6[i]; fs1 = (i == 0);
        apply();
      end
    fs1 = 1'b0; din1 = '0;

    // lock and publish 1101
    repeat (3) send0(4'b1101, 4'b0001);
    // missing sync, then relock
    send0(4'b1101, 4'b0000);
    repeat (3) send0(4'b1011, 4'b0001);
    // early sync at slot 2, realign, continue
    send0(4'b0110, 4'b0101);
    din0 = 1'b1; apply(); apply();
    repeat (3) send0(4'b1001, 4'b0001);
    // one-cycle disable mid-frame
    din0 = 1'b1; fs0 = 1'b1; apply();
    din0 = 1'b0; fs0 = 1'b0; apply();
    en0 = 1'b1; apply(); en0 = 1'b0;
    repeat (3) send0(4'b0011, 4'b0001);
    // reset at slot 3 while locked
    fs0 = 1'b1; apply(); fs0 = 1'b0; apply(); apply();
    rst0 = 1'b1; din0 = 1'b1; apply(); rst0 = 1'b0;
    repeat (3) send0(4'b1110, 4'b0001);

    // random traffic with occasional sync glitches, disables and resets
    ph0 = 0; ph1 = 0;
    for (int c = 0; c < 800; c++) begin
      din0 = 1'($urandom);
      din1 = 2'($urandom);
      fs0  = (ph0 == 0) ^ ($urandom_range(99) < 4);
      fs1  = (ph1 == 0) ^ ($urandom_range(99) < 4);
      en0  = ($urandom_range(99) < 2);
      en1  = ($urandom_range(99) < 2);
      rst0 = ($urandom_range(99) < 1);
      rst1 = ($urandom_range(99) < 1);
      ph0 = (ph0 + 1) % 4;
      ph1 = (ph1 + 1) % 4;
      apply();
    end
    rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b0; en1 = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
    apply(); apply();
    done = 1'b1;
  end

endmodule
